// File: rtl/gradient_scheduler.sv
// gradient_scheduler: steps the gradient engine over a masked set of pyramid images.
// Optional per-image watchdog is built when GRAD_SCHED_TIMEOUT_EN is defined.
module gradient_scheduler #(
    parameter int NUM_IMAGES     = 4,
    parameter int IDX_W          = $clog2(NUM_IMAGES),
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [NUM_IMAGES-1:0] image_mask_in,
    input  logic                  abort_in,
    input  logic                  grad_done_in,
    output logic                  grad_start_out,
    output logic [IDX_W-1:0]      sel_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [IDX_W:0]        images_done_out,
    output logic                  aborted_out,
    output logic                  timeout_out
);

    // Reject configurations the scan logic cannot handle.
    if (NUM_IMAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("gradient_scheduler: NUM_IMAGES must be >= 2, TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ARM,
        S_WAIT,
        S_DRAIN,
        S_FINISH
    } state_t;

    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NUM_IMAGES);

    state_t                state_q, state_d;
    logic [NUM_IMAGES-1:0] mask_q, mask_d;
    logic [IDX_W:0]        idx_q, idx_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [IDX_W:0]        cnt_q, cnt_d;
    logic [IDX_W:0]        cnt_inc;
    logic                  gstart_q, gstart_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;

`ifdef GRAD_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_q, timeout_d;
`endif

    // Image counter saturates at NUM_IMAGES.
    assign cnt_inc = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        gstart_d  = 1'b0;
        busy_d    = busy_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;
`ifdef GRAD_SCHED_TIMEOUT_EN
        timer_d   = timer_q;
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    mask_d    = image_mask_in;
                    idx_d     = '0;
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_SCAN;
`ifdef GRAD_SCHED_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            S_SCAN: begin
                if (abort_in) begin
                    aborted_d = 1'b1;
                    state_d   = S_FINISH;
                end else if (idx_q == LAST) begin
                    state_d = S_FINISH;
                end else if (mask_q[idx_q[IDX_W-1:0]]) begin
                    sel_d   = idx_q[IDX_W-1:0];
                    state_d = S_ARM;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_ARM: begin
                if (abort_in) begin
                    aborted_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    gstart_d = 1'b1;
                    state_d  = S_WAIT;
`ifdef GRAD_SCHED_TIMEOUT_EN
                    timer_d  = '0;
`endif
                end
            end
            S_WAIT: begin
                if (grad_done_in) begin
                    cnt_d = cnt_inc;
                    if (abort_in) begin
                        aborted_d = 1'b1;
                        state_d   = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SCAN;
                    end
                end else if (abort_in) begin
                    aborted_d = 1'b1;
                    state_d   = S_DRAIN;
`ifdef GRAD_SCHED_TIMEOUT_EN
                    timer_d   = timer_q + 1'b1;
                end else if (timer_q == TMAX) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end
            S_DRAIN: begin
                if (grad_done_in) begin
                    cnt_d   = cnt_inc;
                    state_d = S_FINISH;
`ifdef GRAD_SCHED_TIMEOUT_EN
                end else if (timer_q == TMAX) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // done_out is high for exactly the cycle spent in FINISH.
        done_d = (state_d == S_FINISH) && (state_q != S_FINISH);
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            gstart_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            gstart_q  <= gstart_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

`ifdef GRAD_SCHED_TIMEOUT_EN
    // Watchdog timer and sticky timeout flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_out = timeout_q;
`else
    assign timeout_out = 1'b0;
`endif

    assign grad_start_out  = gstart_q;
    assign sel_out         = sel_q;
    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign images_done_out = cnt_q;
    assign aborted_out     = aborted_q;

endmodule

// File: tb/tb_gradient_scheduler.sv
// tb_gradient_scheduler: directed scenarios for gradient_scheduler.
// Timeout scenario is compiled only with GRAD_SCHED_TIMEOUT_EN.
module tb_gradient_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  mask;
    logic          abort;
    logic          eng_done;
    logic          man_done;
    logic          grad_done;
    logic          grad_start;
    logic [IW-1:0] sel;
    logic          busy;
    logic          done_o;
    logic [IW:0]   images;
    logic          aborted;
    logic          timeout;

    int checks = 0;
    int errors = 0;
    int sel_log[$];
    int done_cnt = 0;
    bit eng_en = 1'b0;

    always #5 clk = ~clk;

    assign grad_done = eng_done | man_done;

    gradient_scheduler #(
        .NUM_IMAGES     (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .start_in        (start),
        .image_mask_in   (mask),
        .abort_in        (abort),
        .grad_done_in    (grad_done),
        .grad_start_out  (grad_start),
        .sel_out         (sel),
        .busy_out        (busy),
        .done_out        (done_o),
        .images_done_out (images),
        .aborted_out     (aborted),
        .timeout_out     (timeout)
    );

    // Engine model: done pulse sampled 10 cycles after each start pulse.
    initial begin
        eng_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (eng_en && grad_start) begin
                repeat (9) @(posedge clk);
                #1 eng_done = 1'b1;
                @(posedge clk);
                #1 eng_done = 1'b0;
            end
        end
    end

    // Record every start pulse (with its select) and every done pulse.
    always @(negedge clk) begin
        if (grad_start) sel_log.push_back(int'(sel));
        if (done_o) done_cnt++;
    end

    task automatic pulse_start(input logic [N-1:0] m);
        @(negedge clk);
        mask  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mask  = '0;
    endtask

    task automatic wait_done(input int maxc, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < maxc) begin
            @(negedge clk);
            n++;
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_gstart(input int count, input int maxc, output bit ok);
        int seen = 0;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (grad_start) seen++;
            if (seen == count) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        @(negedge clk);
        sel_log.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mask = '0;
        abort = 1'b0;
        man_done = 1'b0;
        #23;
        checks++;
        if ({busy, grad_start, done_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b exp 000", {busy, grad_start, done_o});
        end
        checks++;
        if ({sel, images} !== '0) begin
            errors++;
            $display("FAIL reset_sel_cnt: sel %0d cnt %0d exp 0 0", sel, images);
        end
        checks++;
        if ({aborted, timeout} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 00", {aborted, timeout});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || grad_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy %b gstart %b exp 0 0", busy, grad_start);
        end
    endtask

    task automatic test_full();
        int exp_sel[4] = '{0, 1, 2, 3};
        int n;
        bit ok;
        eng_en = 1'b1;
        clear_logs();
        pulse_start(4'b1111);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL full_busy_rise: got %b exp 1", busy);
        end
        @(negedge clk);
        checks++;
        if (sel !== 2'd0 || grad_start !== 1'b0) begin
            errors++;
            $display("FAIL full_e1: sel %0d gstart %b exp 0 0", sel, grad_start);
        end
        @(negedge clk);
        checks++;
        if (grad_start !== 1'b1) begin
            errors++;
            $display("FAIL full_e2_gstart: got %b exp 1", grad_start);
        end
        @(negedge clk);
        checks++;
        if (grad_start !== 1'b0) begin
            errors++;
            $display("FAIL full_e3_gstart: got %b exp 0", grad_start);
        end
        wait_done(200, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_done_timeout: no done_out in %0d cycles", n);
        end
        checks++;
        if (images !== 3'd4 || busy !== 1'b1 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL full_at_done: cnt %0d busy %b abt %b exp 4 1 0",
                     images, busy, aborted);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_o !== 1'b0 || sel !== 2'd3) begin
            errors++;
            $display("FAIL full_after: busy %b done %b sel %0d exp 0 0 3",
                     busy, done_o, sel);
        end
        checks++;
        if (sel_log.size() != 4 || done_cnt != 1) begin
            errors++;
            $display("FAIL full_counts: starts %0d dones %0d exp 4 1",
                     sel_log.size(), done_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= sel_log.size() || sel_log[i] != exp_sel[i]) begin
                errors++;
                $display("FAIL full_sel%0d: got %0d exp %0d", i,
                         (i < sel_log.size()) ? sel_log[i] : -1, exp_sel[i]);
            end
        end
    endtask

    task automatic test_sparse();
        int n;
        bit ok;
        eng_en = 1'b1;
        clear_logs();
        pulse_start(4'b1010);
        wait_done(200, n, ok);
        checks++;
        if (!ok || images !== 3'd2) begin
            errors++;
            $display("FAIL sparse_done: ok %b cnt %0d exp 1 2", ok, images);
        end
        @(negedge clk);
        checks++;
        if (sel_log.size() != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL sparse_counts: starts %0d dones %0d exp 2 1",
                     sel_log.size(), done_cnt);
        end
        checks++;
        if (sel_log.size() < 2 || sel_log[0] != 1 || sel_log[1] != 3) begin
            errors++;
            $display("FAIL sparse_sel: got %p exp 1 3", sel_log);
        end
    endtask

    task automatic test_zero_mask();
        int n;
        bit ok;
        clear_logs();
        pulse_start(4'b0000);
        wait_done(20, n, ok);
        checks++;
        if (!ok || n != 5) begin
            errors++;
            $display("FAIL zero_latency: ok %b cycles %0d exp 1 5", ok, n);
        end
        checks++;
        if (images !== 3'd0) begin
            errors++;
            $display("FAIL zero_cnt: got %0d exp 0", images);
        end
        @(negedge clk);
        checks++;
        if (sel_log.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: starts %0d busy %b exp 0 0",
                     sel_log.size(), busy);
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit seen_done = 1'b0;
        eng_en = 1'b1;
        clear_logs();
        pulse_start(4'b1111);
        wait_gstart(2, 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_second_start: not seen in budget");
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (aborted !== 1'b1 || busy !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_drain: abt %b busy %b done %b exp 1 1 0",
                     aborted, busy, done_o);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (grad_done) begin
                seen_done = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL abort_engine_done: not seen in budget");
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_done_timing: got %b exp 1", done_o);
        end
        checks++;
        if (images !== 3'd2 || aborted !== 1'b1 || sel !== 2'd1) begin
            errors++;
            $display("FAIL abort_status: cnt %0d abt %b sel %0d exp 2 1 1",
                     images, aborted, sel);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (sel_log.size() != 2 || done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: starts %0d dones %0d busy %b exp 2 1 0",
                     sel_log.size(), done_cnt, busy);
        end
    endtask

    task automatic test_ignored();
        int n;
        bit ok;
        eng_en = 1'b1;
        clear_logs();
        pulse_start(4'b0011);
        wait_gstart(1, 20, ok);
        mask  = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mask  = '0;
        wait_done(200, n, ok);
        checks++;
        if (!ok || images !== 3'd2 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: ok %b cnt %0d abt %b exp 1 2 0",
                     ok, images, aborted);
        end
        @(negedge clk);
        checks++;
        if (sel_log.size() != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL ignore_start_counts: starts %0d dones %0d exp 2 1",
                     sel_log.size(), done_cnt);
        end
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || images !== 3'd2 || done_cnt != 1 ||
            sel_log.size() != 2) begin
            errors++;
            $display("FAIL ignore_idle_done: busy %b cnt %0d dones %0d starts %0d exp 0 2 1 2",
                     busy, images, done_cnt, sel_log.size());
        end
    endtask

    task automatic test_reset_mid();
        int exp_sel[4] = '{0, 1, 2, 3};
        int n;
        bit ok;
        eng_en = 1'b1;
        clear_logs();
        pulse_start(4'b1111);
        wait_gstart(2, 100, ok);
        @(negedge clk);
        checks++;
        if (images !== 3'd1 || sel !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: cnt %0d sel %0d busy %b exp 1 1 1",
                     images, sel, busy);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, grad_start, done_o, aborted, timeout} !== 5'b0 ||
            sel !== 2'd0 || images !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_async: busy %b sel %0d cnt %0d exp 0 0 0",
                     busy, sel, images);
        end
        eng_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_done: dones %0d busy %b exp 0 0",
                     done_cnt, busy);
        end
        eng_en = 1'b1;
        clear_logs();
        pulse_start(4'b1111);
        wait_done(200, n, ok);
        checks++;
        if (!ok || images !== 3'd4) begin
            errors++;
            $display("FAIL rstmid_rerun: ok %b cnt %0d exp 1 4", ok, images);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= sel_log.size() || sel_log[i] != exp_sel[i]) begin
                errors++;
                $display("FAIL rstmid_sel%0d: got %0d exp %0d", i,
                         (i < sel_log.size()) ? sel_log[i] : -1, exp_sel[i]);
            end
        end
    endtask

`ifdef GRAD_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit ok;
        eng_en = 1'b0;
        clear_logs();
        pulse_start(4'b0001);
        wait_gstart(1, 10, ok);
        wait_done(40, n, ok);
        checks++;
        if (!ok || n != 16) begin
            errors++;
            $display("FAIL timeout_latency: ok %b cycles %0d exp 1 16", ok, n);
        end
        checks++;
        if (timeout !== 1'b1 || images !== 3'd0 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags: to %b cnt %0d abt %b exp 1 0 0",
                     timeout, images, aborted);
        end
        pulse_start(4'b0001);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b exp 0", timeout);
        end
        wait_gstart(1, 10, ok);
        repeat (15) @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        wait_done(20, n, ok);
        checks++;
        if (!ok || timeout !== 1'b0 || images !== 3'd1) begin
            errors++;
            $display("FAIL timeout_done_wins: ok %b to %b cnt %0d exp 1 0 1",
                     ok, timeout, images);
        end
    endtask
`else
    task automatic test_no_timeout();
        int n;
        bit ok;
        eng_en = 1'b0;
        clear_logs();
        pulse_start(4'b0001);
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || timeout !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL notimeout_wait: busy %b to %b dones %0d exp 1 0 0",
                     busy, timeout, done_cnt);
        end
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        wait_done(20, n, ok);
        checks++;
        if (!ok || images !== 3'd1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL notimeout_done: ok %b cnt %0d to %b exp 1 1 0",
                     ok, images, timeout);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full();
        test_sparse();
        test_zero_mask();
        test_abort();
        test_ignored();
        test_reset_mid();
`ifdef GRAD_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
